deserializer: RTL

- Receive end of the 19-bit serial address/data link.
- Samples SERIAL_IN and the LAST_BIT_IN end-of-frame marker every CLK, MSB first, and rebuilds {ADDR[2:0], DATA[15:0]} words.
- Buffers recovered words in a small FIFO and presents them on a valid/ready port.
- Flags short frames and FIFO overflow.

---
 rtl/deserializer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Receive side of the 19-bit serial address/data link: resynchronises the
// serial stream, rebuilds {ADDR, DATA} frames and queues them on a valid/ready port.
module deserializer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SERIAL_IN,
  input  logic        LAST_BIT_IN,
  output logic [2:0]  OUT_ADDR,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] FRAME_COUNT,
  output logic        ERR_SHORT,
  output logic        ERR_OVERFLOW,
  input  logic        CLR_ERR
);

  localparam int unsigned FRAME_W = 19;
  localparam int unsigned BC_W    = 5;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;

  logic w_s_data;
  logic w_s_last;

  // Input synchronisers (bypassed when the source already runs on CLK)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s_data = SERIAL_IN;
      assign w_s_last = LAST_BIT_IN;
    end else if (SYNC_STAGES == 1) begin : g_sync1
      logic r_sync_data;
      logic r_sync_last;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_sync_data <= 1'b0;
          r_sync_last <= 1'b0;
        end else begin
          r_sync_data <= SERIAL_IN;
          r_sync_last <= LAST_BIT_IN;
        end
      end
      assign w_s_data = r_sync_data;
      assign w_s_last = r_sync_last;
    end else begin : g_syncn
      logic [SYNC_STAGES-1:0] r_sync_data;
      logic [SYNC_STAGES-1:0] r_sync_last;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_sync_data <= '0;
          r_sync_last <= '0;
        end else begin
          r_sync_data <= {r_sync_data[SYNC_STAGES-2:0], SERIAL_IN};
          r_sync_last <= {r_sync_last[SYNC_STAGES-2:0], LAST_BIT_IN};
        end
      end
      assign w_s_data = r_sync_data[SYNC_STAGES-1];
      assign w_s_last = r_sync_last[SYNC_STAGES-1];
    end
  endgenerate

  logic [FRAME_W-2:0] r_sr;
  logic               r_last_q;
  logic [BC_W-1:0]    r_bc;

  logic               w_end;
  logic               w_short;
  logic [FRAME_W-1:0] w_frame;

  assign w_end   = w_s_last & ~r_last_q;
  // Counting the bit arriving this cycle, fewer than FRAME_W bits is short
  assign w_short = (r_bc < BC_W'(FRAME_W - 1));
  assign w_frame = {r_sr, w_s_data};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sr     <= '0;
      r_last_q <= 1'b0;
      r_bc     <= '0;
    end else begin
      r_sr     <= {r_sr[FRAME_W-3:0], w_s_data};
      r_last_q <= w_s_last;
      if (w_end) begin
        r_bc <= '0;
      end else if (r_bc != BC_W'(FRAME_W)) begin
        r_bc <= r_bc + BC_W'(1);
      end
    end
  end

  // Output queue: registered head plus a backing ring holding FIFO_DEPTH-1 words
  logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_bq_cnt;
  logic [FRAME_W-1:0] r_head;
  logic               r_head_valid;

  logic w_bq_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf;
  logic w_take;
  logic w_bq_rd;
  logic w_bq_wr;

  assign w_bq_empty = (r_bq_cnt == '0);
  assign w_full     = r_head_valid & (r_bq_cnt == CNT_W'(FIFO_DEPTH - 1));
  assign w_pop      = r_head_valid & OUT_READY;
  assign w_push     = w_end & ~w_short & (~w_full | w_pop);
  assign w_ovf      = w_end & ~w_short & w_full & ~w_pop;
  assign w_take     = ~r_head_valid | w_pop;
  assign w_bq_rd    = w_take & ~w_bq_empty;
  assign w_bq_wr    = w_push & ~(w_take & w_bq_empty);

  always_ff @(posedge CLK) begin
    if (w_bq_wr) begin
      r_mem[r_wr_ptr] <= w_frame;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_bq_cnt     <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_bq_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_bq_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_bq_wr, w_bq_rd})
        2'b10:   r_bq_cnt <= r_bq_cnt + CNT_W'(1);
        2'b01:   r_bq_cnt <= r_bq_cnt - CNT_W'(1);
        default: r_bq_cnt <= r_bq_cnt;
      endcase
      // Refill the head whenever it is empty or being consumed
      if (w_take) begin
        if (!w_bq_empty) begin
          r_head       <= r_mem[r_rd_ptr];
          r_head_valid <= 1'b1;
        end else if (w_push) begin
          r_head       <= w_frame;
          r_head_valid <= 1'b1;
        end else begin
          r_head_valid <= 1'b0;
        end
      end
    end
  end

  logic [15:0] r_frame_count;
  logic        r_err_short;
  logic        r_err_overflow;

  // Sticky flags: a new error in the clear cycle keeps the flag set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_count  <= '0;
      r_err_short    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_end & w_short) begin
        r_err_short <= 1'b1;
      end else if (CLR_ERR) begin
        r_err_short <= 1'b0;
      end
      if (w_ovf) begin
        r_err_overflow <= 1'b1;
      end else if (CLR_ERR) begin
        r_err_overflow <= 1'b0;
      end
    end
  end

  assign OUT_VALID    = r_head_valid;
  assign OUT_ADDR     = r_head[FRAME_W-1:16];
  assign OUT_DATA     = r_head[15:0];
  assign FRAME_COUNT  = r_frame_count;
  assign ERR_SHORT    = r_err_short;
  assign ERR_OVERFLOW = r_err_overflow;

endmodule
